regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 96 +++++++++
 tb/tb_regfile_mp.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
//------------------------------------------------------------------------------
// regfile_mp : multi-read-port register file, registered reads, optional zero reg
// Optional feature macro: REGFILE_BYPASS_EN (write-first forwarding)
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_mp #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [NRD-1:0]             rd_en,
  input  logic [NRD*$clog2(DEPTH)-1:0] rd_addr,
  output logic [NRD*WIDTH-1:0]       rd_data,
  output logic [NRD-1:0]             rd_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] C_ZERO_ADDR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic             w_wr_ok;

  assign w_wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == C_ZERO_ADDR));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_rdval;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    assign w_addr = rd_addr[p*AW +: AW];

    // Binary mux tree: level AW holds the registers, level 0 the selected word;
    // level d picks between sibling pairs using address bit AW-1-d.
    for (genvar d = 0; d <= AW; d++) begin : g_lvl
      logic [WIDTH-1:0] w_lvl [0:(1<<d)-1];
      if (d == AW) begin : g_leaf
        for (genvar k = 0; k < DEPTH; k++) begin : g_k
          if ((ZERO_REG != 0) && (k == DEPTH - 1)) begin : g_zero
            assign w_lvl[k] = '0;
          end else begin : g_reg
            assign w_lvl[k] = r_regs[k];
          end
        end
      end else begin : g_node
        for (genvar j = 0; j < (1 << d); j++) begin : g_j
          assign w_lvl[j] = w_addr[AW-1-d] ? g_lvl[d+1].w_lvl[2*j+1]
                                           : g_lvl[d+1].w_lvl[2*j];
        end
      end
    end

`ifdef REGFILE_BYPASS_EN
    // The zero register never forwards since its write is discarded anyway.
    assign w_rdval = (w_wr_ok && (wr_addr == w_addr)) ? wr_data : g_lvl[0].w_lvl[0];
`else
    assign w_rdval = g_lvl[0].w_lvl[0];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= rd_en[p];
        if (rd_en[p]) begin
          r_data <= w_rdval;
        end
      end
    end

    assign rd_data[p*WIDTH +: WIDTH] = r_data;
    assign rd_valid[p]               = r_valid;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
//------------------------------------------------------------------------------
// tb_regfile_mp : directed vector table plus reset/sweep sequences for regfile_mp
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // Default-parameter instance
  logic         a_we;
  logic [4:0]   a_waddr;
  logic [63:0]  a_wdata;
  logic [1:0]   a_ren;
  logic [9:0]   a_raddr;
  logic [127:0] a_rdata;
  logic [1:0]   a_rvalid;

  // Sweep instance: WIDTH=32, DEPTH=16, NRD=4, ZERO_REG=0
  logic         b_we;
  logic [3:0]   b_waddr;
  logic [31:0]  b_wdata;
  logic [3:0]   b_ren;
  logic [15:0]  b_raddr;
  logic [127:0] b_rdata;
  logic [3:0]   b_rvalid;

  regfile_mp u_dut_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (a_we),
    .wr_addr  (a_waddr),
    .wr_data  (a_wdata),
    .rd_en    (a_ren),
    .rd_addr  (a_raddr),
    .rd_data  (a_rdata),
    .rd_valid (a_rvalid)
  );

  regfile_mp #(.WIDTH(32), .DEPTH(16), .NRD(4), .ZERO_REG(0)) u_dut_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (b_we),
    .wr_addr  (b_waddr),
    .wr_data  (b_wdata),
    .rd_en    (b_ren),
    .rd_addr  (b_raddr),
    .rd_data  (b_rdata),
    .rd_valid (b_rvalid)
  );

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam logic [63:0] COL_EXP = 64'h2;
  localparam logic [63:0] FIRST_EXP = 64'h99;
`else
  localparam bit BYP = 1'b0;
  localparam logic [63:0] COL_EXP = 64'h1;
  localparam logic [63:0] FIRST_EXP = 64'h0;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [1:0]  ren;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [1:0]  ev;
    logic [63:0] e0;
    logic [63:0] e1;
  } vec_t;

  vec_t vt [14];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                         input logic [1:0] ren, input logic [4:0] ra0, input logic [4:0] ra1);
    a_we    = we;
    a_waddr = wa;
    a_wdata = wd;
    a_ren   = ren;
    a_raddr = {ra1, ra0};
  endtask

  logic [31:0] model [16];
  logic [31:0] exp_d [4];
  logic [3:0]  exp_v;

  initial begin
    vt[0]  = '{1'b1, 5'd5,  64'hDEADBEEF_CAFEF00D, 2'b00, 5'd0,  5'd0,  2'b00, 64'h0, 64'h0};
    vt[1]  = '{1'b0, 5'd0,  64'h0,                 2'b11, 5'd5,  5'd5,  2'b11, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D};
    vt[2]  = '{1'b1, 5'd31, 64'hFFFFFFFF_FFFFFFFF, 2'b00, 5'd0,  5'd0,  2'b00, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D};
    vt[3]  = '{1'b0, 5'd0,  64'h0,                 2'b01, 5'd31, 5'd0,  2'b01, 64'h0, 64'hDEADBEEF_CAFEF00D};
    vt[4]  = '{1'b1, 5'd31, 64'hFFFFFFFF_FFFFFFFF, 2'b11, 5'd31, 5'd31, 2'b11, 64'h0, 64'h0};
    vt[5]  = '{1'b1, 5'd7,  64'h1,                 2'b00, 5'd0,  5'd0,  2'b00, 64'h0, 64'h0};
    vt[6]  = '{1'b1, 5'd7,  64'h2,                 2'b01, 5'd7,  5'd0,  2'b01, COL_EXP, 64'h0};
    vt[7]  = '{1'b0, 5'd0,  64'h0,                 2'b10, 5'd0,  5'd7,  2'b10, COL_EXP, 64'h2};
    vt[8]  = '{1'b1, 5'd3,  64'hAA,                2'b00, 5'd0,  5'd0,  2'b00, COL_EXP, 64'h2};
    vt[9]  = '{1'b0, 5'd0,  64'h0,                 2'b01, 5'd3,  5'd0,  2'b01, 64'hAA, 64'h2};
    vt[10] = '{1'b1, 5'd3,  64'hBB,                2'b00, 5'd3,  5'd3,  2'b00, 64'hAA, 64'h2};
    vt[11] = '{1'b0, 5'd0,  64'h0,                 2'b00, 5'd3,  5'd3,  2'b00, 64'hAA, 64'h2};
    vt[12] = '{1'b0, 5'd0,  64'h0,                 2'b00, 5'd3,  5'd3,  2'b00, 64'hAA, 64'h2};
    vt[13] = '{1'b0, 5'd0,  64'h0,                 2'b11, 5'd3,  5'd5,  2'b11, 64'hBB, 64'hDEADBEEF_CAFEF00D};

    reset_n = 1'b0;
    drive_a(1'b0, 5'd0, 64'h0, 2'b00, 5'd0, 5'd0);
    b_we = 1'b0; b_waddr = '0; b_wdata = '0; b_ren = '0; b_raddr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid_a", {62'h0, a_rvalid}, 64'h0);
    chk("reset_data_a0", a_rdata[63:0], 64'h0);
    chk("reset_data_a1", a_rdata[127:64], 64'h0);
    chk("reset_valid_b", {60'h0, b_rvalid}, 64'h0);

    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive_a(vt[i].we, vt[i].wa, vt[i].wd, vt[i].ren, vt[i].ra0, vt[i].ra1);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), {62'h0, a_rvalid}, {62'h0, vt[i].ev});
      chk($sformatf("vec%0d_data0", i), a_rdata[63:0], vt[i].e0);
      chk($sformatf("vec%0d_data1", i), a_rdata[127:64], vt[i].e1);
      @(negedge clk);
    end

    // Reset arriving mid-read clears outputs without a clock edge
    drive_a(1'b0, 5'd0, 64'h0, 2'b11, 5'd5, 5'd7);
    @(posedge clk);
    #1;
    chk("preRst_valid", {62'h0, a_rvalid}, 64'h3);
    chk("preRst_data0", a_rdata[63:0], 64'hDEADBEEF_CAFEF00D);
    chk("preRst_data1", a_rdata[127:64], 64'h2);
    #1 reset_n = 1'b0;
    #1;
    chk("asyncRst_valid", {62'h0, a_rvalid}, 64'h0);
    chk("asyncRst_data0", a_rdata[63:0], 64'h0);
    chk("asyncRst_data1", a_rdata[127:64], 64'h0);
    @(posedge clk);
    #1;
    chk("inRst_valid", {62'h0, a_rvalid}, 64'h0);

    // First edge after release: write reg 9 and read it in the same cycle
    @(negedge clk);
    reset_n = 1'b1;
    drive_a(1'b1, 5'd9, 64'h99, 2'b01, 5'd9, 5'd0);
    @(posedge clk);
    #1;
    chk("firstEdge_valid", {62'h0, a_rvalid}, 64'h1);
    chk("firstEdge_data0", a_rdata[63:0], FIRST_EXP);

    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      drive_a(1'b0, 5'd0, 64'h0, 2'b01, 5'(a), 5'd0);
      @(posedge clk);
      #1;
      chk($sformatf("scan%0d_data0", a), a_rdata[63:0], (a == 9) ? 64'h99 : 64'h0);
    end
    @(negedge clk);
    drive_a(1'b0, 5'd0, 64'h0, 2'b00, 5'd0, 5'd0);

    // Sweep instance: reg 15 must be writable when ZERO_REG=0
    for (int r = 0; r < 16; r++) model[r] = '0;
    for (int p = 0; p < 4; p++) exp_d[p] = '0;
    b_we = 1'b1; b_waddr = 4'd15; b_wdata = 32'h12345678; b_ren = 4'b0000;
    @(posedge clk);
    #1;
    model[15] = 32'h12345678;
    @(negedge clk);
    b_we = 1'b0; b_ren = 4'b1000; b_raddr = {4'd15, 12'h0};
    @(posedge clk);
    #1;
    exp_d[3] = 32'h12345678;
    chk("reg15_data3", {32'h0, b_rdata[127:96]}, 64'h12345678);
    chk("reg15_valid", {60'h0, b_rvalid}, 64'h8);

    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      b_we    = 1'($urandom_range(0, 1));
      b_waddr = 4'($urandom_range(0, 15));
      b_wdata = $urandom;
      b_ren   = 4'($urandom_range(0, 15));
      b_raddr = 16'($urandom);
      for (int p = 0; p < 4; p++) begin
        if (b_ren[p]) begin
          if (BYP && b_we && (b_waddr == b_raddr[p*4 +: 4]))
            exp_d[p] = b_wdata;
          else
            exp_d[p] = model[b_raddr[p*4 +: 4]];
        end
      end
      exp_v = b_ren;
      @(posedge clk);
      #1;
      if (b_we) model[b_waddr] = b_wdata;
      chk("sweep_valid", {60'h0, b_rvalid}, {60'h0, exp_v});
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("sweep_c%0d_p%0d", c, p), {32'h0, b_rdata[p*32 +: 32]}, {32'h0, exp_d[p]});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
